// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word RAM between the fetch and data ports, data first on conflict
module mem_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ready,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [31:0]       d_addr,
    input  logic [3:0]        d_byteen,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_byteen,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACK_I = 2'd1;
    localparam logic [1:0] ACK_D = 2'd2;

    logic [1:0]  state, state_nxt;
    logic [31:0] i_hold, d_hold;
    logic        d_wr_q;
    logic        i_gnt, d_gnt;
    logic        unused_bits;

    assign unused_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

    // Grant, RAM drive and ack outputs; the acking port is masked so its held req is not reissued,
    // and nothing is issued while reset is high.
    always_comb begin
        d_gnt      = d_req & (state != ACK_D) & ~reset;
        i_gnt      = i_req & (state != ACK_I) & ~reset & ~d_gnt;
        mem_en     = d_gnt | i_gnt;
        mem_addr   = d_gnt ? d_addr[ADDR_W+1:2] : i_gnt ? i_addr[ADDR_W+1:2] : '0;
        mem_byteen = d_gnt ? d_byteen : 4'b0;
        mem_wdata  = d_gnt ? d_wdata : 32'b0;
        state_nxt  = d_gnt ? ACK_D : i_gnt ? ACK_I : IDLE;
        i_ready    = (state == ACK_I);
        d_ready    = (state == ACK_D);
        i_rdata    = i_ready ? mem_rdata : i_hold;
        d_rdata    = (d_ready & ~d_wr_q) ? mem_rdata : d_hold;
    end

    // State advance and capture of returned read data so it stays visible after the ack pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            d_wr_q <= 1'b0;
            i_hold <= 32'b0;
            d_hold <= 32'b0;
        end else begin
            state  <= state_nxt;
            d_wr_q <= d_gnt & (|d_byteen);
            if (i_ready) i_hold <= mem_rdata;
            if (d_ready & ~d_wr_q) d_hold <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario checks for mem_arbiter against a behavioural RAM
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_byteen = '0;
    logic        i_ready, d_ready, mem_en;
    logic [31:0] i_rdata, d_rdata, mem_wdata;
    logic [11:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_rdata = '0;
    logic [31:0] ram [0:4095];
    int total = 0;
    int bad = 0;

    mem_arbiter #(.ADDR_W(12)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_byteen(d_byteen), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: one-cycle read latency, per-lane writes
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_byteen[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    a_i_hold: assert property (@(posedge clk) disable iff (reset) (i_req && !i_ready) |=> i_req)
        else $error("protocol: i_req dropped before i_ready");
    a_d_hold: assert property (@(posedge clk) disable iff (reset) (d_req && !d_ready) |=> d_req)
        else $error("protocol: d_req dropped before d_ready");

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        i_req = 1; d_req = 1; i_addr = 32'h3000; d_addr = 32'h40; d_byteen = 4'hF; d_wdata = 32'h11223344;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
            total++; if (mem_addr !== 12'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
            total++; if (mem_byteen !== 4'h0) begin bad++; $display("FAIL rst_mem_byteen got=%h exp=0", mem_byteen); end
            total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
            total++; if ({i_ready, d_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", {i_ready, d_ready}); end
            total++; if (i_rdata !== 32'h0) begin bad++; $display("FAIL rst_i_rdata got=%h exp=0", i_rdata); end
            total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); end
            tick;
        end
        i_req = 0; d_req = 0; d_byteen = 0; d_wdata = 0;
        tick;
        reset = 0;
        tick;
    endtask

    task automatic test_solo_fetch;
        i_addr = 32'h3000; i_req = 1;
        @(negedge clk);
        total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL fetch_issue_en got=%b exp=1", mem_en); end
        total++; if (mem_addr !== 12'hC00) begin bad++; $display("FAIL fetch_addr got=%h exp=c00", mem_addr); end
        total++; if (mem_byteen !== 4'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL fetch_wr got=%h/%h exp=0/0", mem_byteen, mem_wdata); end
        total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL fetch_early_ready got=%b exp=0", i_ready); end
        tick;
        @(negedge clk);
        total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL fetch_ready got=%b exp=1", i_ready); end
        total++; if (i_rdata !== 32'h12345678) begin bad++; $display("FAIL fetch_rdata got=%h exp=12345678", i_rdata); end
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL fetch_no_reissue got=%b exp=0", mem_en); end
        tick;
        i_req = 0;
        tick;
        @(negedge clk);
        total++; if (i_rdata !== 32'h12345678) begin bad++; $display("FAIL fetch_hold got=%h exp=12345678", i_rdata); end
        total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL fetch_ready_pulse got=%b exp=0", i_ready); end
        tick;
    endtask

    task automatic test_conflict;
        d_addr = 32'h10; d_byteen = 0; i_addr = 32'h20; d_req = 1; i_req = 1;
        @(negedge clk);
        total++; if (mem_addr !== 12'h4) begin bad++; $display("FAIL conf_first_addr got=%h exp=4", mem_addr); end
        tick;
        @(negedge clk);
        total++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin bad++; $display("FAIL conf_d_ready got=%b%b exp=10", d_ready, i_ready); end
        total++; if (d_rdata !== 32'hA0A0A0A4) begin bad++; $display("FAIL conf_d_rdata got=%h exp=a0a0a0a4", d_rdata); end
        total++; if (mem_en !== 1'b1 || mem_addr !== 12'h8) begin bad++; $display("FAIL conf_second_addr got=%b/%h exp=1/8", mem_en, mem_addr); end
        tick;
        d_req = 0;
        @(negedge clk);
        total++; if (i_ready !== 1'b1 || d_ready !== 1'b0) begin bad++; $display("FAIL conf_i_ready got=%b%b exp=10", i_ready, d_ready); end
        total++; if (i_rdata !== 32'hB0B0B0B8) begin bad++; $display("FAIL conf_i_rdata got=%h exp=b0b0b0b8", i_rdata); end
        tick;
        i_req = 0;
        tick;
    endtask

    task automatic test_write_read;
        d_addr = 32'h40; d_byteen = 4'hF; d_wdata = 32'hDEADBEEF; d_req = 1;
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || mem_addr !== 12'h10) begin bad++; $display("FAIL wr_issue got=%b/%h exp=1/10", mem_en, mem_addr); end
        total++; if (mem_byteen !== 4'hF || mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data got=%h/%h exp=f/deadbeef", mem_byteen, mem_wdata); end
        tick;
        @(negedge clk);
        total++; if (d_ready !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", d_ready); end
        total++; if (d_rdata !== 32'hA0A0A0A4) begin bad++; $display("FAIL wr_keeps_hold got=%h exp=a0a0a0a4", d_rdata); end
        tick;
        d_byteen = 0; d_wdata = 0;
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || mem_byteen !== 4'h0) begin bad++; $display("FAIL rd_issue got=%b/%h exp=1/0", mem_en, mem_byteen); end
        tick;
        @(negedge clk);
        total++; if (d_ready !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_after_wr got=%b/%h exp=1/deadbeef", d_ready, d_rdata); end
        tick;
        d_byteen = 4'b0010; d_wdata = 32'h55555555;
        @(negedge clk);
        total++; if (mem_byteen !== 4'b0010) begin bad++; $display("FAIL sb_byteen got=%h exp=2", mem_byteen); end
        tick;
        tick;
        d_byteen = 0; d_wdata = 0;
        tick;
        @(negedge clk);
        total++; if (d_ready !== 1'b1 || d_rdata !== 32'hDEAD55EF) begin bad++; $display("FAIL sb_result got=%b/%h exp=1/dead55ef", d_ready, d_rdata); end
        tick;
        d_req = 0;
        tick;
        @(negedge clk);
        total++; if (d_rdata !== 32'hDEAD55EF) begin bad++; $display("FAIL sb_hold got=%h exp=dead55ef", d_rdata); end
        tick;
    endtask

    task automatic test_saturation;
        int nd = 0;
        int ni = 0;
        logic [11:0] exp_addr;
        d_addr = 32'h100; d_byteen = 0; i_addr = 32'h200; d_req = 1; i_req = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp_addr = (k % 2 == 0) ? 12'h040 : 12'h080;
            total++; if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin bad++; $display("FAIL sat_grant k=%0d got=%b/%h exp=1/%h", k, mem_en, mem_addr, exp_addr); end
            total++; if (d_ready !== (k % 2 == 1)) begin bad++; $display("FAIL sat_alt k=%0d got=%b exp=%b", k, d_ready, (k % 2 == 1)); end
            if (d_ready) nd++;
            if (i_ready) ni++;
            tick;
        end
        d_req = 0;
        @(negedge clk);
        if (i_ready) ni++;
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL sat_drain got=%b exp=0", mem_en); end
        tick;
        i_req = 0;
        total++; if (nd < 9 || nd > 11) begin bad++; $display("FAIL sat_d_acks got=%0d exp=10", nd); end
        total++; if (ni < 9 || ni > 11) begin bad++; $display("FAIL sat_i_acks got=%0d exp=10", ni); end
        tick;
    endtask

    task automatic test_reset_midop;
        d_addr = 32'h10; d_byteen = 0; d_req = 1;
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || mem_addr !== 12'h4) begin bad++; $display("FAIL mid_issue got=%b/%h exp=1/4", mem_en, mem_addr); end
        tick;
        reset = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (d_ready !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL mid_no_ack k=%0d got=%b/%b exp=0/0", k, d_ready, mem_en); end
            total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL mid_rdata k=%0d got=%h exp=0", k, d_rdata); end
            tick;
        end
        reset = 0;
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || mem_addr !== 12'h4 || d_ready !== 1'b0) begin bad++; $display("FAIL mid_reissue got=%b/%h/%b exp=1/4/0", mem_en, mem_addr, d_ready); end
        tick;
        @(negedge clk);
        total++; if (d_ready !== 1'b1 || d_rdata !== 32'hA0A0A0A4) begin bad++; $display("FAIL mid_complete got=%b/%h exp=1/a0a0a0a4", d_ready, d_rdata); end
        tick;
        d_req = 0;
        @(negedge clk);
        total++; if (d_ready !== 1'b0 || d_rdata !== 32'hA0A0A0A4) begin bad++; $display("FAIL mid_hold got=%b/%h exp=0/a0a0a0a4", d_ready, d_rdata); end
        tick;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) ram[a] = 32'h0;
        ram[12'hC00] = 32'h12345678;
        ram[12'h004] = 32'hA0A0A0A4;
        ram[12'h008] = 32'hB0B0B0B8;
        #1;
        test_reset;
        test_solo_fetch;
        test_conflict;
        test_write_read;
        test_saturation;
        test_reset_midop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
